// File: rtl/hazard_fwd_unit_p.sv
// hazard_fwd_unit_p: ID-stage hazard detection and operand-forwarding control.
// It keeps its own shift pipeline of in-flight destination tags (entry 1 = EX,
// entry FWD_STAGES = WB). It drives the per-source forwarding selects,
// load-use bubbles, multi-cycle data-memory freezes and taken-branch flushes.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_fwd_unit_p #(
    parameter int REG_AW     = 4,
    parameter int NUM_SRC    = 3,
    parameter int FWD_STAGES = 3,
    parameter int MEM_LAT    = 1,
    parameter int PC_IDX     = 15,
    // derived from FWD_STAGES; leave at its default
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]         id_src_use,
    input  logic [REG_AW-1:0]          id_rd,
    input  logic                       id_rf_en,
    input  logic                       id_load,
    input  logic                       br_taken,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic                       pc_en,
    output logic                       ifid_le,
    output logic                       nop_sel,
    output logic                       ifid_flush
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]                stall_cnt,
    output logic [15:0]                flush_cnt
`endif
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    // tag pipeline, index 1 = EX
    logic [FWD_STAGES:1]             v_q, v_d;
    logic [FWD_STAGES:1]             rf_en_q, rf_en_d;
    logic [FWD_STAGES:1]             ld_q, ld_d;
    logic [FWD_STAGES:1][REG_AW-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;

    logic [NUM_SRC*SEL_W-1:0] fwd_raw;
    logic                     luh;
    logic                     frz;
    logic                     s2_load;

    // a valid load sitting in MEM (stage 2); absent for a single tracked stage
    if (FWD_STAGES >= 2) begin : g_s2
        assign s2_load = v_q[2] & ld_q[2];
    end else begin : g_no_s2
        assign s2_load = 1'b0;
    end

    // youngest matching stage per source, plus load-use detection against EX
    always_comb begin
        fwd_raw = '0;
        luh     = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int s = FWD_STAGES; s >= 1; s--) begin
                if (id_src_use[k] && v_q[s] && rf_en_q[s] &&
                    rd_q[s] == id_src[k*REG_AW +: REG_AW] &&
                    id_src[k*REG_AW +: REG_AW] != REG_AW'(PC_IDX)) begin
                    fwd_raw[k*SEL_W +: SEL_W] = SEL_W'(s);
                    if (s == 1 && ld_q[1] && id_valid)
                        luh = 1'b1;
                end
            end
        end
    end

    // memory freeze: MEM_LAT-1 held cycles starting when a load lands in MEM;
    // the cycle the counter reads 1 is already the release cycle
    always_comb begin
        cnt_d = cnt_q;
        frz   = 1'b0;
        if (MEM_LAT > 1) begin
            if (cnt_q == '0) begin
                if (s2_load) begin
                    cnt_d = CNT_W'(MEM_LAT - 1);
                    frz   = 1'b1;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
                frz   = (cnt_q != CNT_W'(1));
            end
        end
    end

    // pipeline control outputs, priority reset > freeze > load-use > branch
    always_comb begin
        pc_en      = 1'b1;
        ifid_le    = 1'b1;
        nop_sel    = 1'b0;
        ifid_flush = 1'b0;
        fwd_sel    = fwd_raw;
        if (!CLR) begin
            pc_en   = 1'b0;
            ifid_le = 1'b0;
            nop_sel = 1'b1;
            fwd_sel = '0;
        end else if (frz) begin
            pc_en   = 1'b0;
            ifid_le = 1'b0;
        end else if (luh) begin
            pc_en   = 1'b0;
            ifid_le = 1'b0;
            nop_sel = 1'b1;
        end else if (br_taken) begin
            ifid_flush = 1'b1;
        end
    end

    // tag shift: hold on freeze, otherwise ID (or a bubble) enters EX
    always_comb begin
        v_d     = v_q;
        rd_d    = rd_q;
        rf_en_d = rf_en_q;
        ld_d    = ld_q;
        if (!frz) begin
            v_d[1]     = id_valid & ~nop_sel;
            rd_d[1]    = id_rd;
            rf_en_d[1] = id_rf_en;
            ld_d[1]    = id_load;
            for (int s = 2; s <= FWD_STAGES; s++) begin
                v_d[s]     = v_q[s-1];
                rd_d[s]    = rd_q[s-1];
                rf_en_d[s] = rf_en_q[s-1];
                ld_d[s]    = ld_q[s-1];
            end
        end
    end

    // state registers with synchronous active-low clear
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            v_q     <= '0;
            rd_q    <= '0;
            rf_en_q <= '0;
            ld_q    <= '0;
            cnt_q   <= '0;
        end else begin
            v_q     <= v_d;
            rd_q    <= rd_d;
            rf_en_q <= rf_en_d;
            ld_q    <= ld_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((frz || luh) && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (ifid_flush && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // counter registers
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    // no performance counters in this build
`endif

endmodule

// File: tb/tb_hazard_fwd_unit_p.sv
// Directed bench for hazard_fwd_unit_p: a default instance (MEM_LAT=1) and a
// MEM_LAT=3 instance share the stimulus; expected values are hand-derived.
module tb_hazard_fwd_unit_p;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        id_valid;
    logic [11:0] id_src;
    logic [2:0]  id_src_use;
    logic [3:0]  id_rd;
    logic        id_rf_en;
    logic        id_load;
    logic        br_taken;

    logic [5:0]  fwd_sel,  l_fwd_sel;
    logic        pc_en,    l_pc_en;
    logic        ifid_le,  l_ifid_le;
    logic        nop_sel,  l_nop_sel;
    logic        ifid_flush, l_ifid_flush;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt, l_stall_cnt, l_flush_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    hazard_fwd_unit_p u_dut (
        .CLK(CLK), .CLR(CLR), .id_valid(id_valid), .id_src(id_src),
        .id_src_use(id_src_use), .id_rd(id_rd), .id_rf_en(id_rf_en),
        .id_load(id_load), .br_taken(br_taken), .fwd_sel(fwd_sel),
        .pc_en(pc_en), .ifid_le(ifid_le), .nop_sel(nop_sel),
        .ifid_flush(ifid_flush)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    hazard_fwd_unit_p #(.MEM_LAT(3)) u_lat (
        .CLK(CLK), .CLR(CLR), .id_valid(id_valid), .id_src(id_src),
        .id_src_use(id_src_use), .id_rd(id_rd), .id_rf_en(id_rf_en),
        .id_load(id_load), .br_taken(br_taken), .fwd_sel(l_fwd_sel),
        .pc_en(l_pc_en), .ifid_le(l_ifid_le), .nop_sel(l_nop_sel),
        .ifid_flush(l_ifid_flush)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(l_stall_cnt), .flush_cnt(l_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    // control outputs of the default instance packed {pc_en, ifid_le, nop_sel, ifid_flush}
    function automatic logic [3:0] ctl();
        return {pc_en, ifid_le, nop_sel, ifid_flush};
    endfunction

    function automatic logic [3:0] lctl();
        return {l_pc_en, l_ifid_le, l_nop_sel, l_ifid_flush};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // drive one ID instruction
    task automatic id_set(input logic v, input logic [3:0] rd, input logic rf,
                          input logic ld, input logic [11:0] src, input logic [2:0] use_m);
        id_valid   = v;
        id_rd      = rd;
        id_rf_en   = rf;
        id_load    = ld;
        id_src     = src;
        id_src_use = use_m;
    endtask

    initial begin
        CLR = 1'b0;
        br_taken = 1'b1;
        id_set(1'b0, 4'd0, 1'b0, 1'b0, 12'h000, 3'b000);

        // reset held for two edges; outputs forced, flush suppressed
        #1;
        chk("rst_ctl", 32'(ctl()), 32'b0010);
        chk("rst_fwd", 32'(fwd_sel), 32'h0);
        tick();
        chk("rst_ctl2", 32'(ctl()), 32'b0010);
        tick();
        CLR = 1'b1;
        br_taken = 1'b0;
        #1;
        chk("rel_ctl", 32'(ctl()), 32'b1100);
        chk("rel_fwd", 32'(fwd_sel), 32'h0);

        // EX/MEM/WB forwarding of R1 to src0; src1/src2 name R1 but are unused
        id_set(1'b1, 4'd1, 1'b1, 1'b0, 12'h000, 3'b000);
        tick();
        id_set(1'b1, 4'd0, 1'b0, 1'b0, 12'h111, 3'b001);
        #1; chk("fwd_ex",  32'(fwd_sel), 32'h01);
        tick(); chk("fwd_mem", 32'(fwd_sel), 32'h02);
        tick(); chk("fwd_wb",  32'(fwd_sel), 32'h03);
        tick(); chk("fwd_none", 32'(fwd_sel), 32'h00);
        chk("fwd_ctl", 32'(ctl()), 32'b1100);

        // youngest wins: R2 in stages 1 and 3, R5 in stage 2
        id_set(1'b1, 4'd2, 1'b1, 1'b0, 12'h000, 3'b000); tick();
        id_set(1'b1, 4'd5, 1'b1, 1'b0, 12'h000, 3'b000); tick();
        id_set(1'b1, 4'd2, 1'b1, 1'b0, 12'h000, 3'b000); tick();
        id_set(1'b1, 4'd0, 1'b0, 1'b0, 12'h025, 3'b011);
        #1; chk("prio_fwd", 32'(fwd_sel), 32'h06);

        // load-use on src2: one bubble, branch ignored while stalled
        id_set(1'b1, 4'd3, 1'b1, 1'b1, 12'h000, 3'b000); tick();
        id_set(1'b1, 4'd0, 1'b0, 1'b0, 12'h300, 3'b100);
        br_taken = 1'b1;
        #1;
        chk("luh_ctl", 32'(ctl()), 32'b0010);
        chk("luh_fwd", 32'(fwd_sel), 32'h10);
        br_taken = 1'b0;
        tick();
        chk("luh_rel_ctl", 32'(ctl()), 32'b1100);
        chk("luh_rel_fwd", 32'(fwd_sel), 32'h20);

        // MEM_LAT=3 freeze on the second instance
        CLR = 1'b0; tick(); CLR = 1'b1;
        id_set(1'b1, 4'd4, 1'b1, 1'b1, 12'h000, 3'b000); tick();
        id_set(1'b1, 4'd6, 1'b1, 1'b0, 12'h000, 3'b000); tick();
        id_set(1'b1, 4'd7, 1'b1, 1'b0, 12'h046, 3'b011);
        br_taken = 1'b1;
        #1;
        chk("frz1_ctl", 32'(lctl()), 32'b0000);
        chk("frz1_fwd", 32'(l_fwd_sel), 32'h09);
        tick();
        chk("frz2_ctl", 32'(lctl()), 32'b0000);
        chk("frz2_fwd", 32'(l_fwd_sel), 32'h09);
        tick();
        chk("frz_rel_ctl", 32'(lctl()), 32'b1101);
        chk("frz_rel_fwd", 32'(l_fwd_sel), 32'h09);
        br_taken = 1'b0;
        tick();
        chk("frz_adv_fwd", 32'(l_fwd_sel), 32'h0E);
        chk("frz_adv_ctl", 32'(lctl()), 32'b1100);

        // PC is never forwarded; then a clean taken branch
        CLR = 1'b0; tick(); CLR = 1'b1;
`ifdef HAZ_PERF_CNT_EN
        chk("flush_cnt0", 32'(flush_cnt), 32'd0);
`endif
        id_set(1'b1, 4'd15, 1'b1, 1'b0, 12'h000, 3'b000); tick();
        id_set(1'b1, 4'd0, 1'b0, 1'b0, 12'h00F, 3'b001);
        #1;
        chk("pc_fwd", 32'(fwd_sel), 32'h00);
        chk("pc_ctl", 32'(ctl()), 32'b1100);
        tick();
        id_set(1'b1, 4'd0, 1'b0, 1'b0, 12'h000, 3'b000);
        br_taken = 1'b1;
        #1;
        chk("br_ctl", 32'(ctl()), 32'b1101);
        tick();
        br_taken = 1'b0;
        #1;
        chk("br_after", 32'(ctl()), 32'b1100);
`ifdef HAZ_PERF_CNT_EN
        chk("flush_cnt1", 32'(flush_cnt), 32'd1);
        chk("stall_cnt0", 32'(stall_cnt), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit_p.md
Name: hazard_fwd_unit_p

Overview:
- Parametrised successor to the fixed 5-stage hazard/forwarding unit in the ARM pipeline core.
- Holds its own shift pipeline of in-flight destination tags (EX, MEM, WB...), so the stage count is not hardwired.
- Generates per-source forwarding selects for any number of ID read ports, load-use bubbles, multi-cycle data-memory freezes and taken-branch IF/ID flushes.
- Sits in ID and drives PC enable, IF/ID latch enable, the control-unit NOP mux select and the ID operand muxes.

Parameters:
- REG_AW, 4, register index width.
- NUM_SRC, 3, number of ID source ports (Rn, Rm, Rd-as-store-data).
- FWD_STAGES, 3, number of tracked stages after ID (1=EX ... FWD_STAGES=WB); range 1..7.
- MEM_LAT, 1, data-memory load latency in cycles; range 1..8.
- PC_IDX, 15, register index never forwarded (program counter).

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  reset, synchronous, active-low.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_AW  source indices; port k is bits [k*REG_AW +: REG_AW].
- id_src_use  in  NUM_SRC  source k is actually read.
- id_rd  in  REG_AW  ID destination.
- id_rf_en  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load.
- br_taken  in  1  condition handler: branch in ID taken.
- fwd_sel  out  NUM_SRC*SEL_W  per-source select; 0 = register file, s = stage s result. SEL_W = $clog2(FWD_STAGES+1).
- pc_en  out  1  PC load enable.
- ifid_le  out  1  IF/ID load enable.
- nop_sel  out  1  force control-unit mux to NOP.
- ifid_flush  out  1  clear IF/ID.

Behaviour:
- Tag pipeline: FWD_STAGES entries {v, rd, rf_en, ld}; entry 1 = EX.
- Reset: while CLR=0 at a rising edge, all entries clear to v=0 and the latency counter goes to 0. While CLR=0, outputs are forced to pc_en=0, ifid_le=0, nop_sel=1, ifid_flush=0, fwd_sel=0.
- Match rule: source k matches stage s when id_src_use[k], entry s has v=1 and rf_en=1, rd==id_src[k], and id_src[k]!=PC_IDX.
- Forwarding: fwd_sel[k] = the smallest matching s (youngest wins); 0 if there is no match. It is combinational from the current entries.
- Load-use hazard (luh): id_valid and any source matches stage 1 with ld=1. When luh is set:
  - pc_en=0, ifid_le=0, nop_sel=1.
  - Next edge: entry1 <= bubble (v=0); other entries shift.
- Memory freeze (frz): applies when MEM_LAT>1. When stage 2 holds v=1 and ld=1 and the counter is 0, the counter loads MEM_LAT-1.
  - While the counter is nonzero: pc_en=0, ifid_le=0, nop_sel=0, and the whole tag pipeline holds.
  - The counter decrements each cycle; release happens on the cycle it reads 1.
  - A new load reaching stage 2 reloads the counter.
- Branch: br_taken with no luh and no frz gives ifid_flush=1 for exactly one cycle, and the ID instruction enters entry1 normally.
- Priority: frz > luh > branch.
  - br_taken is ignored during luh (its branch is the stalled instruction) and during frz.
  - Flush is never asserted in the same cycle as ifid_le=0.
- Normal advance: entry1 <= {id_valid & ~nop_sel, id_rd, id_rf_en, id_load}; entry s+1 <= entry s; the last entry is discarded.
- WB-stage forwarding covers same-cycle write/read because the register file writes on the edge.
- Reset mid-stall: the counter clears and all pending bubbles and flushes are dropped.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[15:0] (cycles with luh or frz) and flush_cnt[15:0] (ifid_flush pulses). Both are saturating at 16'hFFFF and cleared by CLR=0.
- Undefined: these ports and their logic do not exist.

Test Plan:
- Reset: CLR=0 for 2 cycles, then 1 -> pc_en=1, ifid_le=1, nop_sel=0, fwd_sel=0 on the first cycle after release.
- EX forward, defaults: ADD R1 enters; next cycle ID reads R1 on src0 -> fwd_sel[1:0]=1. One cycle later -> 2. Then -> 3. Then -> 0.
- Priority: R2 written by the instructions in both stage 1 and stage 3, ID reads R2 on src1 -> fwd_sel[3:2]=1.
- Load-use: LDR R3 in EX, ID uses R3 on src2 -> one cycle of pc_en=0, ifid_le=0, nop_sel=1. Next cycle fwd_sel[5:4]=2 and the stall is released.
- MEM_LAT=3: load reaches MEM -> exactly 2 frozen cycles. Tags are unchanged and br_taken=1 is asserted meanwhile with ifid_flush staying 0.
- PC_IDX: the stage-1 instruction writes R15 and ID reads R15 -> fwd_sel=0. Then br_taken=1 with no hazard -> ifid_flush=1 for one cycle. With HAZ_PERF_CNT_EN, flush_cnt increments 0->1.
